// File: rtl/led_breathe_pwm.sv
// LED driver with OFF/SOLID/BLINK/BREATHE modes.
// In BREATHE mode a tick-driven FSM ramps a PWM duty level up and down, holding at each extreme.
module led_breathe_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                tick,
    input  logic [1:0]          mode,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic [2:0]          phase
);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_SOLID   = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS+1)'(STEP);
    localparam int                  HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    function automatic logic [PWM_BITS-1:0] sat_add(input logic [PWM_BITS-1:0] a);
        logic [PWM_BITS:0] sum;
        sum = {1'b0, a} + STEP_X;
        if (sum > {1'b0, LVL_MAX}) sat_add = LVL_MAX;
        else                       sat_add = sum[PWM_BITS-1:0];
    endfunction

    function automatic logic [PWM_BITS-1:0] sat_sub(input logic [PWM_BITS-1:0] a);
        if ({1'b0, a} < STEP_X) sat_sub = '0;
        else                    sat_sub = a - STEP_X[PWM_BITS-1:0];
    endfunction

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                blink_q, blink_d;
    logic                led_q, led_d;
    logic [1:0]          mode_prev_q, mode_prev_d;
    logic                en_prev_q, en_prev_d;
    logic                tick_ok;

    // A tick arriving on the same cycle en rises is dropped.
    assign tick_ok = tick & en & en_prev_q;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        hold_cnt_d  = hold_cnt_q;
        blink_d     = blink_q;
        led_d       = 1'b0;
        mode_prev_d = mode;
        en_prev_d   = en;
        pwm_cnt_d   = en ? pwm_cnt_q + 1'b1 : '0;

        if (en) begin
            case (mode)
                MODE_OFF:   led_d = 1'b0;
                MODE_SOLID: led_d = 1'b1;
                MODE_BLINK: led_d = blink_q;
                default:    led_d = (pwm_cnt_q < level_q);
            endcase
        end

        if (mode != mode_prev_q) begin
            state_d    = IDLE;
            level_d    = '0;
            hold_cnt_d = '0;
            blink_d    = 1'b0;
        end else if (en) begin
            if (mode != MODE_BREATHE) begin
                state_d    = IDLE;
                level_d    = '0;
                hold_cnt_d = '0;
                if (mode == MODE_BLINK && tick_ok) blink_d = ~blink_q;
            end else begin
                case (state_q)
                    IDLE: state_d = UP;
                    UP: if (tick_ok) begin
                        level_d = sat_add(level_q);
                        if (level_d == LVL_MAX) begin
                            state_d    = HOLD_HI;
                            hold_cnt_d = '0;
                        end
                    end
                    HOLD_HI: if (tick_ok) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d    = DOWN;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    DOWN: if (tick_ok) begin
                        level_d = sat_sub(level_q);
                        if (level_d == '0) begin
                            state_d    = HOLD_LO;
                            hold_cnt_d = '0;
                        end
                    end
                    HOLD_LO: if (tick_ok) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d    = UP;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d    = IDLE;
                        level_d    = '0;
                        hold_cnt_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            level_q     <= '0;
            pwm_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            blink_q     <= 1'b0;
            led_q       <= 1'b0;
            mode_prev_q <= MODE_OFF;
            en_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            pwm_cnt_q   <= pwm_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_q     <= blink_d;
            led_q       <= led_d;
            mode_prev_q <= mode_prev_d;
            en_prev_q   <= en_prev_d;
        end
    end

    assign led   = led_q;
    assign level = level_q;
    assign phase = state_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm: a default instance and a STEP=100 / HOLD_TICKS=3 instance.
module tb_led_breathe_pwm;

    logic       clk = 1'b0;
    logic       rst_n, rst_n_b, en, tick;
    logic [1:0] mode;
    logic       led_a, led_b;
    logic [7:0] level_a, level_b;
    logic [2:0] phase_a, phase_b;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         lvl;
    int         highs;
    logic [7:0] pwm_m;
    logic [7:0] pprev;

    always #5 clk = ~clk;

    led_breathe_pwm dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .mode(mode),
        .led(led_a), .level(level_a), .phase(phase_a)
    );

    led_breathe_pwm #(.PWM_BITS(8), .STEP(100), .HOLD_TICKS(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en), .tick(tick), .mode(mode),
        .led(led_b), .level(level_b), .phase(phase_b)
    );

    // Reference PWM counter for instance A
    always @(posedge clk) pwm_m <= (!rst_n || !en) ? 8'd0 : pwm_m + 8'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(3);
    endtask

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0; en = 1'b0; tick = 1'b0; mode = 2'b00;
        step(2);
        chk("rst_led", led_a, 0);
        chk("rst_level", level_a, 0);
        chk("rst_phase", phase_a, 0);

        rst_n = 1'b1; en = 1'b1; mode = 2'b11;
        step(3);
        chk("idle_to_up", phase_a, 1);
        chk("up_start_level", level_a, 0);

        for (int i = 1; i <= 255; i++) begin
            do_tick();
            chk("up_level", level_a, i);
        end
        chk("up_to_hold_hi", phase_a, 2);

        for (int i = 1; i <= 16; i++) begin
            do_tick();
            chk("hold_hi_phase", phase_a, (i < 16) ? 2 : 3);
            chk("hold_hi_level", level_a, 255);
        end

        lvl = 255;
        while (lvl > 0) begin
            do_tick();
            lvl--;
            chk("down_level", level_a, lvl);
            if (lvl == 90) begin
                en = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    tick = (c % 4 == 1);
                    step(1);
                    chk("en_off_led", led_a, 0);
                    chk("en_off_level", level_a, 90);
                end
                tick = 1'b0;
                chk("en_off_phase", phase_a, 3);
                en = 1'b1; tick = 1'b1;
                step(1);
                tick = 1'b0;
                chk("en_rise_tick_ignored", level_a, 90);
                step(2);
                do_tick();
                chk("resume_level", level_a, 89);
                lvl = 89;
            end
        end
        chk("down_to_hold_lo", phase_a, 4);

        for (int i = 1; i <= 16; i++) begin
            do_tick();
            chk("hold_lo_phase", phase_a, (i < 16) ? 4 : 1);
            chk("hold_lo_level", level_a, 0);
        end
        do_tick();
        chk("reup_level", level_a, 1);

        for (int i = 0; i < 63; i++) do_tick();
        chk("level_64", level_a, 64);

        highs = 0;
        for (int c = 0; c < 256; c++) begin
            step(1);
            pprev = pwm_m - 8'd1;
            chk("pwm_led", led_a, (pprev < 8'd64) ? 1 : 0);
            if (led_a === 1'b1) highs++;
        end
        chk("pwm_high_count", highs, 64);
        chk("no_tick_hold_level", level_a, 64);

        for (int i = 0; i < 56; i++) do_tick();
        chk("level_120", level_a, 120);

        mode = 2'b10; tick = 1'b1;
        step(1);
        tick = 1'b0;
        chk("mode_chg_level", level_a, 0);
        chk("mode_chg_phase", phase_a, 0);
        chk("mode_chg_led", led_a, 0);
        step(2);
        chk("blink_cleared", led_a, 0);
        do_tick();
        chk("blink_on", led_a, 1);
        chk("blink_level", level_a, 0);
        chk("blink_phase", phase_a, 0);
        do_tick();
        chk("blink_off", led_a, 0);

        mode = 2'b00;
        step(2);
        chk("b_rst_led", led_b, 0);
        chk("b_rst_level", level_b, 0);
        chk("b_rst_phase", phase_b, 0);
        chk("off_led", led_a, 0);

        rst_n_b = 1'b1; mode = 2'b11;
        step(3);
        chk("b_idle_to_up", phase_b, 1);
        do_tick(); chk("b_up_100", level_b, 100);
        do_tick(); chk("b_up_200", level_b, 200);
        do_tick(); chk("b_up_sat", level_b, 255);
        chk("b_hold_hi", phase_b, 2);
        do_tick(); chk("b_hold1", phase_b, 2);
        do_tick(); chk("b_hold2", phase_b, 2);
        do_tick(); chk("b_to_down", phase_b, 3);
        chk("b_down_start", level_b, 255);
        do_tick(); chk("b_down_155", level_b, 155);
        do_tick(); chk("b_down_55", level_b, 55);
        do_tick(); chk("b_down_sat", level_b, 0);
        chk("b_hold_lo", phase_b, 4);
        for (int i = 0; i < 3; i++) do_tick();
        chk("b_lo_to_up", phase_b, 1);
        for (int i = 0; i < 3; i++) do_tick();
        chk("b_reup_sat", level_b, 255);
        do_tick();
        chk("b_mid_hold", phase_b, 2);

        rst_n_b = 1'b0; tick = 1'b1;
        step(1);
        tick = 1'b0;
        chk("b_midrst_led", led_b, 0);
        chk("b_midrst_level", level_b, 0);
        chk("b_midrst_phase", phase_b, 0);

        rst_n_b = 1'b1; mode = 2'b01;
        step(2);
        chk("b_solid_led", led_b, 1);
        chk("b_solid_level", level_b, 0);
        chk("b_solid_phase", phase_b, 0);
        chk("a_solid_led", led_a, 1);
        mode = 2'b00;
        step(2);
        chk("b_off_led", led_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_breathe_pwm.md
LED_BREATHE_PWM -- requirements
Module: led_breathe_pwm

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, meaning the width of the PWM counter and duty level.
REQ-002 The block SHALL have parameter STEP, default 1, meaning the duty increment/decrement applied per tick; legal range 1..2^PWM_BITS-1.
REQ-003 The block SHALL have parameter HOLD_TICKS, default 16, meaning the number of ticks spent at each ramp extreme; legal range >=1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: global enable.
REQ-007 The block SHALL have port tick, input, 1 bit: a single-cycle strobe from the upstream clock divider that advances the pattern.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 OFF, 01 SOLID, 10 BLINK, 11 BREATHE.
REQ-009 The block SHALL have port led, output, 1 bit: the registered LED drive.
REQ-010 The block SHALL have port level, output, PWM_BITS bits: the current duty value.
REQ-011 The block SHALL have port phase, output, 3 bits: the current FSM state encoding.

Function
REQ-012 pwm_cnt (PWM_BITS) SHALL increment by 1 every cycle while en=1, wrapping from 2^PWM_BITS-1 to 0.
REQ-013 In BREATHE mode, led SHALL be registered as (pwm_cnt < level), giving one cycle of latency from the compare; level=0 gives a constant 0, level=MAX gives on for MAX of 2^PWM_BITS cycles.
REQ-014 The FSM states SHALL be IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4.
REQ-015 IDLE SHALL go to UP on the cycle after entry whenever mode=BREATHE and en=1.
REQ-016 In UP, each tick SHALL set level=min(level+STEP, MAX) using a saturating add with no wrap; when the new level equals MAX the FSM SHALL go to HOLD_HI and clear hold_cnt.
REQ-017 In HOLD_HI, each tick SHALL increment hold_cnt; on the tick where hold_cnt reaches HOLD_TICKS-1 the FSM SHALL go to DOWN.
REQ-018 In DOWN, each tick SHALL set level=max(level-STEP, 0) using a saturating subtract; when the new level equals 0 the FSM SHALL go to HOLD_LO and clear hold_cnt.
REQ-019 In HOLD_LO, the FSM SHALL count ticks as in HOLD_HI and then go to UP.
REQ-020 Cycles without a tick SHALL leave level, hold_cnt and state unchanged.
REQ-021 In OFF mode, led SHALL be 0, and the FSM and level SHALL be held at IDLE and 0.
REQ-022 In SOLID mode, led SHALL be 1, and the FSM and level SHALL be held at IDLE and 0.
REQ-023 In BLINK mode, each tick SHALL toggle blink_q; led SHALL be blink_q registered; FSM and level SHALL stay at IDLE and 0.
REQ-024 Any change of mode between consecutive cycles SHALL force state=IDLE, level=0, hold_cnt=0 and blink_q=0 on the next edge; this takes priority over a simultaneous tick.
REQ-025 When en=0, led SHALL be 0, pwm_cnt SHALL be 0, and level, state, hold_cnt and blink_q SHALL be frozen; ticks are ignored.
REQ-026 When en returns to 1, operation SHALL resume from the frozen state.
REQ-027 If tick and en rise in the same cycle, the tick SHALL be ignored.
REQ-028 Ticks spaced one cycle apart (back-to-back) SHALL each be honoured.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL set led=0, level=0, phase=IDLE, pwm_cnt=0, hold_cnt=0 and blink_q=0.
REQ-030 Reset SHALL override en, tick and mode, including mid-ramp.
REQ-031 Outputs SHALL be valid from the first edge after rst_n rises.

Verification
REQ-032 The bench SHALL cover: reset, en=1, mode=11, tick every 4 cycles, defaults -> level 0,1,...,255 over 255 ticks, then HOLD_HI for 16 ticks, DOWN to 0, HOLD_LO for 16 ticks, back to UP.
REQ-033 The bench SHALL cover: STEP=100, BREATHE -> level 0,100,200,255 (saturated), then after hold 155,55,0; no wrap.
REQ-034 The bench SHALL cover: BREATHE with level forced to 64, 256-cycle window -> led high for exactly 64 cycles, lagging pwm_cnt by 1 cycle.
REQ-035 The bench SHALL cover: mode changed 11->10 at level 120 in the same cycle as a tick -> next cycle level=0, phase=IDLE, blink_q=0; subsequent ticks toggle led.
REQ-036 The bench SHALL cover: en dropped in DOWN at level 90 for 50 cycles with ticks -> led=0, level stays 90; after en returns, the next tick gives 89.
REQ-037 The bench SHALL cover: rst_n=0 asserted mid-HOLD_HI -> next edge gives led=0, level=0, phase=0; mode=01 after reset -> led=1.
